slave_arbiter: RTL and testbench
================================

# slave_arbiter

Round-robin arbiter sharing one single-ported slave among N masters on the crossbar. Each master issues a one-word read or write. The winner's command is registered onto the slave port and held until the slave acks. Read data is captured from the slave's one-cycle-delayed rdata, then returned to the winner with a one-cycle ack pulse.

## Interface
- N, 4: number of masters, 2..8.
- TIMEOUT, 16: ISSUE cycles without s_ack before abort; used only with ARB_TIMEOUT_EN.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- m_req  in  N  per-master request; held until that master's m_ack.
- m_addr  in  32*N  master i at bits [32*i+31:32*i].
- m_cmd  in  N  1 = write, 0 = read.
- m_wdata  in  32*N  write data, same packing as m_addr.
- m_ack  out  N  one-cycle completion pulse, one-hot or zero.
- m_rdata  out  32  read data; valid while any m_ack bit is high.
- m_err  out  1  timeout abort flag; pulses with m_ack; tied 0 without ARB_TIMEOUT_EN.
- s_req  out  1  slave request.
- s_addr  out  32  slave address.
- s_cmd  out  1  slave command.
- s_wdata  out  32  slave write data.
- s_ack  in  1  slave ack pulse.
- s_rdata  in  32  slave read data; valid one cycle after s_ack.

## Operation
- Reset values:
  - Outputs: s_req = 0, s_addr = 0, s_cmd = 0, s_wdata = 0, m_ack = 0, m_rdata = 0, m_err = 0.
  - Internal: state IDLE, last-grant pointer = N-1 (master 0 wins first), timeout counter 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any m_req bit is set, grant the first requester searching upward from pointer+1, wrapping modulo N.
  - On grant: latch that master's addr, cmd and wdata into s_addr, s_cmd and s_wdata; set s_req = 1; set pointer = grant index; go to ISSUE.
  - If no m_req bit is set, stay in IDLE with all outputs 0.
- ISSUE:
  - s_req stays 1; s_addr, s_cmd and s_wdata stay stable.
  - On s_ack = 1: set s_req = 0 and go to RESP.
- RESP:
  - Load m_rdata with s_rdata on reads, 0 on writes.
  - Set m_ack[grant] = 1 for exactly one cycle; go to IDLE.
- Requesters:
  - A master dropping m_req after it has been granted does not cancel its transaction; it still receives its m_ack.
  - Request bits for non-granted masters are ignored until the FSM returns to IDLE.
- s_ack outside ISSUE is ignored.
- Synchronous reset in any state returns to IDLE and forces every reset value; the in-flight transaction is dropped with no m_ack.

## Timing
- Edge E0: IDLE samples m_req. After E0, s_req is high.
- Edge E1: the slave registers ack and rdata.
- Edge E2: s_ack is sampled, s_req drops, FSM enters RESP.
- Edge E3: s_rdata, already valid, is captured. m_ack and m_rdata are visible in the cycle after E3.
- Latency: 3 cycles from request sample to m_ack, with an immediate-ack slave. Each extra slave wait cycle adds 1.
- E4 is the next arbitration edge. A master that sees m_ack must deassert m_req by E4; otherwise a new transaction is issued.
- Throughput: at most one transaction per 4 cycles.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in ISSUE.
  - After TIMEOUT cycles with s_ack = 0: s_req drops; RESP pulses m_ack[grant] with m_err = 1 and m_rdata = 0.
  - If s_ack and expiry occur in the same cycle, s_ack wins and m_err = 0.
- ARB_TIMEOUT_EN undefined:
  - ISSUE waits for s_ack indefinitely.
  - No counter logic is built; m_err is constant 0.

## Test plan
- Single write, then read: master 1 writes addr 0x10 / data 0xCAFE0001, then reads addr 0x14. Required:
  - Write: s_addr = 0x10 and s_cmd = 1; m_ack[1] appears 3 cycles after the request.
  - Read: m_ack[1] with m_rdata = 0xCAFE0001.
- All four masters request at once, each holding m_req until ack, with distinct addresses. Required: grant order 0, 1, 2, 3; each next s_req rises 1 cycle after the previous m_ack.
- Masters 0 and 2 request continuously. Required: grants alternate 0, 2, 0, 2; no master is starved.
- Master 3 drops m_req the cycle after its grant. Required: its transaction still completes and m_ack[3] pulses once.
- Reset asserted while in ISSUE with s_req = 1. Required: next cycle s_req = 0, no m_ack, and the first grant after reset goes to master 0.
- With ARB_TIMEOUT_EN and TIMEOUT = 16, the slave never acks. Required: s_req drops after 16 ISSUE cycles; m_ack[i] = 1, m_err = 1, m_rdata = 0.

Source files
------------

// File: rtl/slave_arbiter.sv
// slave_arbiter: round-robin arbiter sharing one single-ported slave among N masters.
// Defining ARB_TIMEOUT_EN builds an ISSUE-state timeout that aborts with m_err.
module slave_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    m_req,
  input  logic [32*N-1:0] m_addr,
  input  logic [N-1:0]    m_cmd,
  input  logic [32*N-1:0] m_wdata,
  output logic [N-1:0]    m_ack,
  output logic [31:0]     m_rdata,
  output logic            m_err,
  output logic            s_req,
  output logic [31:0]     s_addr,
  output logic            s_cmd,
  output logic [31:0]     s_wdata,
  input  logic            s_ack,
  input  logic [31:0]     s_rdata
);

  localparam int unsigned PW = $clog2(N);

  if (N < 2 || N > 8 || TIMEOUT == 0) begin : g_param_check
    $error("slave_arbiter: N must be 2..8 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic          r_sreq, w_sreq_nxt;
  logic [31:0]   r_saddr, w_saddr_nxt;
  logic          r_scmd, w_scmd_nxt;
  logic [31:0]   r_swdata, w_swdata_nxt;
  logic [N-1:0]  r_mack, w_mack_nxt;
  logic [31:0]   r_mrdata, w_mrdata_nxt;
  logic          r_merr, w_merr_nxt;

  logic [N-1:0][31:0] w_addr_arr;
  logic [N-1:0][31:0] w_wdata_arr;
  assign w_addr_arr  = m_addr;
  assign w_wdata_arr = m_wdata;

  // First requester strictly after the last grant, wrapping modulo N.
  logic          w_any;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_scan;
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_scan = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_scan = PW'((32'(r_ptr) + k) % N);
      if (!w_any && m_req[w_scan]) begin
        w_any  = 1'b1;
        w_gidx = w_scan;
      end
    end
  end

  logic w_expire;
  logic w_abort;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_abort;

  assign w_expire = (r_state == ISSUE) && (r_tcnt == TW'(TIMEOUT - 1));
  assign w_abort  = r_abort;

  // A same-cycle s_ack beats expiry, so the abort flag only sets without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt  <= '0;
      r_abort <= 1'b0;
    end else if (r_state != ISSUE) begin
      r_tcnt <= '0;
      if (r_state == IDLE) r_abort <= 1'b0;
    end else if (!s_ack) begin
      r_tcnt <= r_tcnt + 1'b1;
      if (w_expire) r_abort <= 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign w_abort  = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_sreq_nxt   = r_sreq;
    w_saddr_nxt  = r_saddr;
    w_scmd_nxt   = r_scmd;
    w_swdata_nxt = r_swdata;
    w_mack_nxt   = '0;
    w_mrdata_nxt = '0;
    w_merr_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ptr_nxt    = w_gidx;
          w_sreq_nxt   = 1'b1;
          w_saddr_nxt  = w_addr_arr[w_gidx];
          w_scmd_nxt   = m_cmd[w_gidx];
          w_swdata_nxt = w_wdata_arr[w_gidx];
          w_state_nxt  = ISSUE;
        end else begin
          w_sreq_nxt   = 1'b0;
          w_saddr_nxt  = '0;
          w_scmd_nxt   = 1'b0;
          w_swdata_nxt = '0;
        end
      end
      ISSUE: begin
        if (s_ack || w_expire) begin
          w_sreq_nxt  = 1'b0;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_mack_nxt[r_ptr] = 1'b1;
        w_mrdata_nxt      = (r_scmd || w_abort) ? '0 : s_rdata;
        w_merr_nxt        = w_abort;
        w_saddr_nxt       = '0;
        w_scmd_nxt        = 1'b0;
        w_swdata_nxt      = '0;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= PW'(N - 1);
      r_sreq   <= 1'b0;
      r_saddr  <= '0;
      r_scmd   <= 1'b0;
      r_swdata <= '0;
      r_mack   <= '0;
      r_mrdata <= '0;
      r_merr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sreq   <= w_sreq_nxt;
      r_saddr  <= w_saddr_nxt;
      r_scmd   <= w_scmd_nxt;
      r_swdata <= w_swdata_nxt;
      r_mack   <= w_mack_nxt;
      r_mrdata <= w_mrdata_nxt;
      r_merr   <= w_merr_nxt;
    end
  end

  assign s_req   = r_sreq;
  assign s_addr  = r_saddr;
  assign s_cmd   = r_scmd;
  assign s_wdata = r_swdata;
  assign m_ack   = r_mack;
  assign m_rdata = r_mrdata;
  assign m_err   = r_merr;

endmodule

// File: tb/tb_slave_arbiter.sv
// tb_slave_arbiter: vector table of single transactions plus hand-written arbitration,
// reset and timeout sequences against a behavioural slave with programmable wait.
`timescale 1ns/1ps
module tb_slave_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    m_req, m_cmd;
  logic [32*N-1:0] m_addr, m_wdata;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rdata;
  logic            m_err;
  logic            s_req, s_cmd;
  logic [31:0]     s_addr, s_wdata;
  logic            s_ack_mdl, stray_ack;
  logic [31:0]     s_rdata;

  slave_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack_mdl | stray_ack), .s_rdata(s_rdata)
  );

  // Slave decodes 16-byte slots (addr[7:4]); acks after slave_wait extra cycles,
  // rdata valid the cycle after the ack pulse.
  logic [31:0] mem [16];
  int          slave_wait = 0;
  initial begin : slave_model
    logic        q_req, q_ack, q_cmd, q_rst;
    logic [31:0] q_addr, q_wdata;
    int          wcnt;
    wcnt = 0;
    s_ack_mdl = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 | i;
    forever begin
      @(negedge clk);
      q_req = s_req; q_ack = s_ack_mdl; q_cmd = s_cmd;
      q_addr = s_addr; q_wdata = s_wdata; q_rst = reset;
      @(posedge clk); #1;
      if (q_rst) begin
        s_ack_mdl = 1'b0; wcnt = 0;
      end else if (q_ack) begin
        s_ack_mdl = 1'b0;
        if (q_cmd) mem[q_addr[7:4]] = q_wdata;
        else       s_rdata = mem[q_addr[7:4]];
      end else if (q_req) begin
        if (wcnt >= slave_wait) begin s_ack_mdl = 1'b1; wcnt = 0; end
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  int          errors = 0, checks = 0, cyc = 0;
  logic        prev_sreq = 1'b0;
  logic [N-1:0] drop_mask;
  int          gq_cyc[$];
  logic [31:0] gq_addr[$];
  int          aq_idx[$];
  int          aq_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (s_req && !prev_sreq) begin gq_cyc.push_back(cyc); gq_addr.push_back(s_addr); end
    prev_sreq = s_req;
    for (int i = 0; i < N; i++)
      if (m_ack[i]) begin aq_idx.push_back(i); aq_cyc.push_back(cyc); end
    m_req = m_req & ~(m_ack & drop_mask);
  endtask

  task automatic set_master(input int i, input logic c, input logic [31:0] a, input logic [31:0] d);
    m_cmd[i] = c;
    m_addr[32*i +: 32] = a;
    m_wdata[32*i +: 32] = d;
  endtask

  task automatic wait_ack(input int bound, output int n);
    n = 0;
    while (m_ack == '0 && n < bound) begin tick(); n++; end
  endtask

  task automatic clear_q();
    gq_cyc.delete(); gq_addr.delete(); aq_idx.delete(); aq_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int          m;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    int          lat;
    logic [N-1:0] ack;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[8];

  initial begin : main
    int n, hi;
    vecs[0] = '{1, 1'b1, 32'h10, 32'hCAFE_0001, 0, 3, 4'b0010, 32'h0};
    vecs[1] = '{1, 1'b0, 32'h14, 32'h1111_1111, 0, 3, 4'b0010, 32'hCAFE_0001};
    vecs[2] = '{2, 1'b0, 32'h20, 32'h2222_2222, 2, 5, 4'b0100, 32'h5A00_0002};
    vecs[3] = '{0, 1'b1, 32'h30, 32'h1234_5678, 1, 4, 4'b0001, 32'h0};
    vecs[4] = '{3, 1'b0, 32'h34, 32'h0,         0, 3, 4'b1000, 32'h1234_5678};
    vecs[5] = '{3, 1'b1, 32'hF0, 32'hFFFF_FFFF, 3, 6, 4'b1000, 32'h0};
    vecs[6] = '{0, 1'b0, 32'hF8, 32'h0,         0, 3, 4'b0001, 32'hFFFF_FFFF};
    vecs[7] = '{2, 1'b0, 32'h00, 32'h0,         0, 3, 4'b0100, 32'h5A00_0000};

    reset = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    stray_ack = 1'b0; drop_mask = '1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst s_req",   s_req,   0);
    check("rst s_addr",  s_addr,  0);
    check("rst s_cmd",   s_cmd,   0);
    check("rst s_wdata", s_wdata, 0);
    check("rst m_ack",   m_ack,   0);
    check("rst m_rdata", m_rdata, 0);
    check("rst m_err",   m_err,   0);

    for (int v = 0; v < 8; v++) begin
      slave_wait = vecs[v].wt;
      set_master(vecs[v].m, vecs[v].cmd, vecs[v].addr, vecs[v].wdata);
      m_req = '0;
      m_req[vecs[v].m] = 1'b1;
      tick();
      check($sformatf("v%0d s_req", v),   s_req,   1);
      check($sformatf("v%0d s_addr", v),  s_addr,  vecs[v].addr);
      check($sformatf("v%0d s_cmd", v),   s_cmd,   vecs[v].cmd);
      check($sformatf("v%0d s_wdata", v), s_wdata, vecs[v].wdata);
      wait_ack(20, n);
      check($sformatf("v%0d latency", v), n,       vecs[v].lat);
      check($sformatf("v%0d m_ack", v),   m_ack,   vecs[v].ack);
      check($sformatf("v%0d m_rdata", v), m_rdata, vecs[v].rdata);
      check($sformatf("v%0d m_err", v),   m_err,   0);
      tick();
      check($sformatf("v%0d idle ctl", v), {m_ack, s_req, s_cmd, m_err}, 0);
      check($sformatf("v%0d idle addr", v), s_addr, 0);
      check($sformatf("v%0d idle rdata", v), m_rdata, 0);
    end

    // s_ack outside ISSUE has no effect
    stray_ack = 1'b1; tick(); stray_ack = 1'b0; tick();
    check("stray m_ack", m_ack, 0);
    check("stray s_req", s_req, 0);

    // all four request together after reset: order 0,1,2,3, back-to-back
    do_reset(); clear_q(); slave_wait = 0; drop_mask = '1;
    for (int i = 0; i < N; i++) set_master(i, 1'b0, 32'h100 + 32'(16 * i), 32'h0);
    m_req = '1;
    n = 0;
    while (aq_idx.size() < 4 && n < 40) begin tick(); n++; end
    check("rr4 count", aq_idx.size(), 4);
    for (int k = 0; k < 4 && k < aq_idx.size(); k++) begin
      check($sformatf("rr4 ack%0d", k),  aq_idx[k],  k);
      check($sformatf("rr4 addr%0d", k), gq_addr[k], 32'h100 + 32'(16 * k));
      if (k > 0) check($sformatf("rr4 gap%0d", k), gq_cyc[k] - aq_cyc[k-1], 1);
    end
    if (aq_cyc.size() > 0) check("rr4 first latency", aq_cyc[0] - gq_cyc[0], 3);
    tick();

    // masters 0 and 2 hold requests: grants must alternate
    clear_q(); drop_mask = '0;
    m_req = 4'b0101;
    n = 0;
    while (aq_idx.size() < 4 && n < 40) begin tick(); n++; end
    m_req = '0; drop_mask = '1;
    check("alt count", aq_idx.size(), 4);
    for (int k = 0; k < 4 && k < aq_idx.size(); k++)
      check($sformatf("alt ack%0d", k), aq_idx[k], (k % 2 == 0) ? 0 : 2);
    tick(); tick();

    // master 3 drops request right after its grant
    clear_q();
    set_master(3, 1'b1, 32'h300, 32'hABCD_0003);
    m_req = 4'b1000;
    tick();
    check("drop grant addr", s_addr, 32'h300);
    m_req = '0;
    repeat (10) tick();
    check("drop ack count", aq_idx.size(), 1);
    if (aq_idx.size() > 0) check("drop ack idx", aq_idx[0], 3);

    // reset during ISSUE drops the transaction and restores the pointer
    clear_q(); slave_wait = 1000;
    set_master(0, 1'b0, 32'h40, 32'h0);
    m_req = 4'b0001;
    tick(); tick();
    check("rstiss s_req before", s_req, 1);
    m_req = '0; reset = 1'b1;
    tick();
    check("rstiss s_req", s_req, 0);
    check("rstiss m_ack", m_ack, 0);
    reset = 1'b0;
    tick();
    check("rstiss m_ack later", m_ack, 0);
    check("rstiss no ack seen", aq_idx.size(), 0);
    slave_wait = 0;
    set_master(0, 1'b0, 32'h400, 32'h0);
    set_master(1, 1'b0, 32'h410, 32'h0);
    m_req = 4'b0011;
    tick();
    check("rstiss first grant", s_addr, 32'h400);
    wait_ack(20, n);
    check("rstiss ack0", m_ack, 4'b0001);
    m_req = '0;
    repeat (6) tick();

`ifdef ARB_TIMEOUT_EN
    // slave never acks: abort after TO ISSUE cycles
    slave_wait = 1_000_000;
    set_master(1, 1'b0, 32'h50, 32'h0);
    m_req = 4'b0010;
    tick();
    hi = s_req ? 1 : 0;
    n = 0;
    while (s_req && n < 40) begin tick(); n++; if (s_req) hi++; end
    check("to s_req cycles", hi, TO);
    wait_ack(5, n);
    check("to latency", n, 1);
    check("to m_ack", m_ack, 4'b0010);
    check("to m_err", m_err, 1);
    check("to m_rdata", m_rdata, 0);
    tick();
    check("to idle err", m_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
